// File: rtl/sd_bd_pkg.sv
// Shared constants for the SD buffer-descriptor ring: BD layout, word
// indices and one-hot FSM encodings for the host-write and master-read sides.
package sd_bd_pkg;

  localparam int BD_WORDS     = 2;
  localparam int BD_DEPTH_DEF = 8;

  localparam logic WORD_SYS_ADR = 1'b0;
  localparam logic WORD_CMD_ARG = 1'b1;

  localparam logic [1:0] W_WORD0 = 2'b01;
  localparam logic [1:0] W_WORD1 = 2'b10;

  localparam logic [3:0] R_IDLE = 4'b0001;
  localparam logic [3:0] R_ACK  = 4'b0010;
  localparam logic [3:0] R_GAP  = 4'b0100;
  localparam logic [3:0] R_DONE = 4'b1000;

endpackage

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor RAM: synchronous write, registered read that
// holds its last value while no read is requested. Contents are not reset.
module sd_bd_ram #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] rdata_q;

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // read port, output register only loads on a read request
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sd_bd_ring_ctrl.sv
// BD ring responder for one SD transfer direction: stores 2-word descriptors
// from the host, hands them word by word to the data master, retires on a_cmp.
module sd_bd_ring_ctrl
  import sd_bd_pkg::*;
#(
  parameter int BD_DEPTH = BD_DEPTH_DEF,
  parameter int PTR_W    = 3,
  parameter int DW       = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we_m,
  input  logic [DW-1:0]  dat_in_m,
  output logic           we_ack_m,
  input  logic           bd_clr,
  input  logic           re_s,
  output logic           ack_o_s,
  output logic [DW-1:0]  dat_out_s,
  input  logic           a_cmp,
  output logic [PTR_W:0] free_bd,
  output logic           ovf_err,
  output logic           und_err,
  input  logic           err_clr
);

  localparam int AW = PTR_W + 1;
  localparam logic [PTR_W:0] FREE_MAX = (PTR_W + 1)'(BD_DEPTH);

  logic             we_ack_q, we_ack_d;
  logic [1:0]       w_state_q, w_state_d;
  logic [3:0]       r_state_q, r_state_d;
  logic [PTR_W-1:0] wr_bd_q, wr_bd_d;
  logic [PTR_W-1:0] rd_bd_q, rd_bd_d;
  logic             rd_word_q, rd_word_d;
  logic [PTR_W:0]   free_q, free_d;
  logic             ovf_q, ovf_d;
  logic             und_q, und_d;
  logic             dat_vld_q, dat_vld_d;

  logic             wr_take_s;
  logic             commit_s;
  logic             retire_s;
  logic             ovf_set_s;
  logic             und_set_s;
  logic             ring_empty_s;
  logic             ram_we_s;
  logic             ram_re_s;
  logic [AW-1:0]    ram_waddr_s;
  logic [AW-1:0]    ram_raddr_s;
  logic [DW-1:0]    ram_rdata_s;

  assign ring_empty_s = (free_q == FREE_MAX);
  // we_m is only looked at while no ack is outstanding
  assign wr_take_s    = we_m & ~we_ack_q;
  assign retire_s     = a_cmp & ~ring_empty_s & ~bd_clr;
  assign und_set_s    = a_cmp & ring_empty_s & ~bd_clr;
  assign ram_raddr_s  = {rd_bd_q, rd_word_q};

  // host write side: two words per BD, commit on the second
  always_comb begin
    we_ack_d    = wr_take_s;
    w_state_d   = w_state_q;
    wr_bd_d     = wr_bd_q;
    ram_we_s    = 1'b0;
    ram_waddr_s = {wr_bd_q, WORD_SYS_ADR};
    commit_s    = 1'b0;
    ovf_set_s   = 1'b0;
    if (bd_clr) begin
      w_state_d = W_WORD0;
      wr_bd_d   = '0;
    end else if (wr_take_s) begin
      case (w_state_q)
        W_WORD0: begin
          if (free_q == '0) begin
            ovf_set_s = 1'b1;
          end else begin
            ram_we_s  = 1'b1;
            w_state_d = W_WORD1;
          end
        end
        W_WORD1: begin
          ram_we_s    = 1'b1;
          ram_waddr_s = {wr_bd_q, WORD_CMD_ARG};
          commit_s    = 1'b1;
          wr_bd_d     = wr_bd_q + 1'b1;
          w_state_d   = W_WORD0;
        end
        default: begin
          w_state_d = W_WORD0;
        end
      endcase
    end else begin
      w_state_d = w_state_q;
    end
  end

  // master read side; a retire overrides any request in the same cycle
  always_comb begin
    r_state_d = r_state_q;
    rd_bd_d   = rd_bd_q;
    rd_word_d = rd_word_q;
    ram_re_s  = 1'b0;
    dat_vld_d = dat_vld_q;
    if (bd_clr) begin
      r_state_d = R_IDLE;
      rd_bd_d   = '0;
      rd_word_d = 1'b0;
    end else if (retire_s) begin
      r_state_d = R_IDLE;
      rd_bd_d   = rd_bd_q + 1'b1;
      rd_word_d = 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (re_s && !ring_empty_s) begin
            ram_re_s  = 1'b1;
            dat_vld_d = 1'b1;
            r_state_d = R_ACK;
          end else begin
            r_state_d = R_IDLE;
          end
        end
        R_ACK: begin
          rd_word_d = ~rd_word_q;
          r_state_d = rd_word_q ? R_DONE : R_GAP;
        end
        R_GAP: begin
          r_state_d = R_IDLE;
        end
        R_DONE: begin
          r_state_d = R_DONE;
        end
        default: begin
          r_state_d = R_IDLE;
        end
      endcase
    end
  end

  // free-slot count; commit and retire in one cycle cancel out
  always_comb begin
    if (bd_clr) begin
      free_d = FREE_MAX;
    end else if (commit_s && !retire_s) begin
      free_d = free_q - 1'b1;
    end else if (retire_s && !commit_s) begin
      free_d = free_q + 1'b1;
    end else begin
      free_d = free_q;
    end
  end

  // sticky error flags, a new error beats a same-cycle clear
  always_comb begin
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q & ~err_clr;
    end
    if (und_set_s) begin
      und_d = 1'b1;
    end else begin
      und_d = und_q & ~err_clr;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_ack_q  <= 1'b0;
      w_state_q <= W_WORD0;
      r_state_q <= R_IDLE;
      wr_bd_q   <= '0;
      rd_bd_q   <= '0;
      rd_word_q <= 1'b0;
      free_q    <= FREE_MAX;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
      dat_vld_q <= 1'b0;
    end else begin
      we_ack_q  <= we_ack_d;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wr_bd_q   <= wr_bd_d;
      rd_bd_q   <= rd_bd_d;
      rd_word_q <= rd_word_d;
      free_q    <= free_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
      dat_vld_q <= dat_vld_d;
    end
  end

  sd_bd_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (dat_in_m),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // RAM output is undefined until the first read after reset
  assign dat_out_s = dat_vld_q ? ram_rdata_s : '0;
  assign we_ack_m  = we_ack_q;
  assign ack_o_s   = (r_state_q == R_ACK);
  assign free_bd   = free_q;
  assign ovf_err   = ovf_q;
  assign und_err   = und_q;

endmodule
